param_serializer: RTL

Parametrised MSB-first parallel-to-serial converter, the next generation of the team's fixed 16-bit serializer. It takes words of `DATA_W` bits with a per-word length, and shifts out the top `len` bits one per clock with a valid strobe. A one-word holding register lets the next word be accepted during shifting, so words stream back-to-back with no idle cycles. It sits between a parallel producer and a single-wire serial sink.

---
 rtl/param_serializer_pkg.sv | 28 ++
 rtl/param_serializer_if.sv | 28 ++
 rtl/param_serializer_counter.sv | 29 ++
 rtl/param_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/param_serializer_pkg.sv
// Shared types and helpers for the parametrised MSB-first serializer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: ser_state_t FSM encoding, DEF_MIN_LEN default, len_legal() check.
// Optional feature macro: SERIALIZER_PARITY_EN adds the PARITY state.
package serializer_pkg;

   localparam int DEF_MIN_LEN = 4;

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;
`else
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;
`endif

   // A length is usable when it lies in min_len..data_w inclusive.
   function automatic logic len_legal(input int len, input int data_w, input int min_len);
      return (len >= min_len) && (len <= data_w);
   endfunction

endpackage

// File: rtl/param_serializer_if.sv
// Producer/serial-sink bundle for param_serializer.
// Latency: n/a (wires only).
// Backpressure: data_rdy_o from the serializer gates data_val_i transfers.
// Ports: master = producer/sink side, slave = serializer side.
interface param_serializer_if #(
   parameter int DATA_W = 16
) ();
   localparam int LEN_W = $clog2(DATA_W + 1);

   logic              data_val_i;
   logic [DATA_W-1:0] data_i;
   logic [LEN_W-1:0]  data_mod_i;
   logic              data_rdy_o;
   logic              ser_data_o;
   logic              ser_data_val_o;
   logic              busy_o;
   logic              len_err_o;

   modport master (
      output data_val_i, data_i, data_mod_i,
      input  data_rdy_o, ser_data_o, ser_data_val_o, busy_o, len_err_o
   );

   modport slave (
      input  data_val_i, data_i, data_mod_i,
      output data_rdy_o, ser_data_o, ser_data_val_o, busy_o, len_err_o
   );
endinterface

// File: rtl/param_serializer_counter.sv
// Loadable down-counter tracking the bits still to send after the current one.
// Latency: load/dec take effect on the next rising edge.
// Backpressure: none; dec is ignored once the count is zero, so it never wraps.
// Ports: clk/rst_n, load + load_val, dec, cnt (current count), zero (cnt == 0).
module ser_bit_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   assign zero = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter: sends the top len bits of each word MSB first.
// Latency: word accepted at edge N drives its first bit in cycle N+1 (registered).
// Backpressure: one-word holding register; data_rdy_o drops only while it is full.
// Ports: clk_i, rst_i (async active-low), bus (param_serializer_if.slave).
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity bit per word.
module param_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int MIN_LEN = DEF_MIN_LEN
) (
   input  logic              clk_i,
   input  logic              rst_i,
   param_serializer_if.slave bus
);

   localparam int LEN_W = $clog2(DATA_W + 1);

   ser_state_t        state;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] hold_dat;
   logic [LEN_W-1:0]  hold_len;
   logic              hold_empty;
   logic              ser_dat_q;
   logic              ser_vld_q;
   logic              busy_q;
   logic              len_err_q;
`ifdef SERIALIZER_PARITY_EN
   logic              par;
`endif

   logic              xfer;
   logic              legal;
   logic              xfer_ok;
   logic              xfer_bad;
   logic              word_end;
   logic              take_hold;
   logic              take_new;
   logic              to_hold;
   logic              load;
   logic              dec;
   logic [DATA_W-1:0] load_dat;
   logic [LEN_W-1:0]  load_len;
   logic [LEN_W-1:0]  cnt;
   logic              cnt_zero;

   always_comb begin
      xfer     = bus.data_val_i && hold_empty;
      legal    = len_legal(int'(bus.data_mod_i), DATA_W, MIN_LEN);
      xfer_ok  = xfer && legal;
      xfer_bad = xfer && !legal;
`ifdef SERIALIZER_PARITY_EN
      // The parity cycle is the last cycle of a word, so successors start from it.
      word_end = (state == PARITY);
`else
      word_end = (state == SHIFT) && cnt_zero;
`endif
      // A held word always has priority; while it is held, rdy is low so no
      // new transfer can coincide with the reload.
      take_hold = word_end && !hold_empty;
      take_new  = xfer_ok && ((state == IDLE) || word_end);
      to_hold   = xfer_ok && !take_new;
      load      = take_hold || take_new;
      load_dat  = take_hold ? hold_dat : bus.data_i;
      load_len  = take_hold ? hold_len : bus.data_mod_i;
      dec       = (state == SHIFT) && !cnt_zero;
   end

   // The counter holds the number of bits remaining after the one on the wire,
   // hence the len-1 load value.
   ser_bit_counter #(
      .W (LEN_W)
   ) u_cnt (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .load     (load),
      .load_val (load_len - LEN_W'(1)),
      .dec      (dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         sreg       <= '0;
         hold_dat   <= '0;
         hold_len   <= '0;
         hold_empty <= 1'b1;
         ser_dat_q  <= 1'b0;
         ser_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         len_err_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         len_err_q <= xfer_bad;

         if (take_hold) begin
            hold_empty <= 1'b1;
         end else if (to_hold) begin
            hold_empty <= 1'b0;
            hold_dat   <= bus.data_i;
            hold_len   <= bus.data_mod_i;
         end

         if (load) begin
            // The MSB goes straight to the output flop; the remainder is shifted.
            state     <= SHIFT;
            ser_dat_q <= load_dat[DATA_W-1];
            ser_vld_q <= 1'b1;
            busy_q    <= 1'b1;
            sreg      <= load_dat << 1;
`ifdef SERIALIZER_PARITY_EN
            par       <= load_dat[DATA_W-1];
`endif
         end else begin
            case (state)
               SHIFT: begin
                  if (!cnt_zero) begin
                     ser_dat_q <= sreg[DATA_W-1];
                     ser_vld_q <= 1'b1;
                     busy_q    <= 1'b1;
                     sreg      <= sreg << 1;
`ifdef SERIALIZER_PARITY_EN
                     par       <= par ^ sreg[DATA_W-1];
`endif
                  end else begin
`ifdef SERIALIZER_PARITY_EN
                     // par already covers every bit sent, including the last.
                     state     <= PARITY;
                     ser_dat_q <= par;
                     ser_vld_q <= 1'b1;
                     busy_q    <= 1'b1;
`else
                     state     <= IDLE;
                     ser_dat_q <= 1'b0;
                     ser_vld_q <= 1'b0;
                     busy_q    <= 1'b0;
`endif
                  end
               end
`ifdef SERIALIZER_PARITY_EN
               PARITY: begin
                  state     <= IDLE;
                  ser_dat_q <= 1'b0;
                  ser_vld_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
`endif
               default: begin
                  state     <= IDLE;
                  ser_dat_q <= 1'b0;
                  ser_vld_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.data_rdy_o     = hold_empty;
   assign bus.ser_data_o     = ser_dat_q;
   assign bus.ser_data_val_o = ser_vld_q;
   assign bus.busy_o         = busy_q;
   assign bus.len_err_o      = len_err_q;

   // Every word ends with the counter drained, so IDLE always sees zero.
   a_idle_cnt_zero : assert property (@(posedge clk_i) disable iff (!rst_i)
      (state == IDLE) |-> (cnt == '0));

endmodule
